// File: rtl/k_test_pkg.sv
// Shared definitions for the K-sequence adder tester: operand width,
// sequence length and the checker state encoding.
package k_test_pkg;

    localparam int DATA_WIDTH             = 6;
    localparam int NUMBER_OF_COMBINATIONS = 1 << DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

endpackage

// File: rtl/k_sum_delay_line.sv
// Shift register of {valid, data} words that lines the golden result up with
// the adder under test; a depth of zero is a plain wire.
module k_sum_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst_n, flush};
            assign out_valid   = in_valid;
            assign out_data    = in_data;
        end else begin : g_shift
            logic [DEPTH-1:0] valid_q;
            logic [WIDTH-1:0] data_q [DEPTH];

            // A flush kills every valid bit so nothing in flight is ever compared.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= '0;
                    for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
                end else begin
                    valid_q[0] <= in_valid & ~flush;
                    data_q[0]  <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1] & ~flush;
                        data_q[i]  <= data_q[i-1];
                    end
                end
            end

            assign out_valid = valid_q[DEPTH-1];
            assign out_data  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/k_sum_checker.sv
// Drives {accumulator, K} operand pairs to the adder under test, compares its
// result with a delayed golden sum and reports pass/fail once the sequence ends.
module k_sum_checker #(
    parameter int DATA_WIDTH    = k_test_pkg::DATA_WIDTH,
    parameter int DUT_LATENCY   = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     test_en,
    input  logic [DATA_WIDTH-1:0]    counter_ammount_i,
    input  logic                     end_test_flag,
    output logic [DATA_WIDTH-1:0]    op_a_o,
    output logic [DATA_WIDTH-1:0]    op_b_o,
    input  logic [DATA_WIDTH:0]      dut_sum_i,
    output logic                     error_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic [ERR_CNT_WIDTH-1:0] vec_count_o,
    output logic [DATA_WIDTH-1:0]    fail_a_o,
    output logic [DATA_WIDTH-1:0]    fail_b_o,
    output logic [DATA_WIDTH:0]      fail_sum_o,
    output logic                     done_o,
    output logic                     pass_o
);

    import k_test_pkg::*;

    localparam int SUM_W  = DATA_WIDTH + 1;
    localparam int LINE_W = 2 * DATA_WIDTH + SUM_W;
    localparam logic [2:0] DRAIN_LOAD = (DUT_LATENCY == 0) ? 3'd0 : 3'(DUT_LATENCY - 1);

    chk_state_t              state;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    ops_valid;
    logic [2:0]              drain_cnt;

    logic [SUM_W-1:0]        line_sum;
    logic [LINE_W-1:0]       line_in;
    logic [LINE_W-1:0]       line_out;
    logic                    line_flush;
    logic                    gold_valid;
    logic [DATA_WIDTH-1:0]   gold_a;
    logic [DATA_WIDTH-1:0]   gold_b;
    logic [SUM_W-1:0]        gold_sum;

    logic                    cmp_en;
    logic                    mismatch;
    logic [ERR_CNT_WIDTH-1:0] err_next;
    logic [ERR_CNT_WIDTH-1:0] vec_next;

    // Operands travel with the golden sum so the first failure can be reported
    // even though op_a_o/op_b_o have moved on by the time the result arrives.
    assign line_sum   = {1'b0, op_a_o} + {1'b0, op_b_o};
    assign line_in    = {op_a_o, op_b_o, line_sum};
    assign line_flush = (state == RUN) && !end_test_flag && !test_en;

    k_sum_delay_line #(
        .DEPTH (DUT_LATENCY),
        .WIDTH (LINE_W)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (line_flush),
        .in_valid  (ops_valid),
        .in_data   (line_in),
        .out_valid (gold_valid),
        .out_data  (line_out)
    );

    assign {gold_a, gold_b, gold_sum} = line_out;
    assign cmp_en   = gold_valid && ((state == RUN) || (state == DRAIN));
    assign mismatch = cmp_en && (dut_sum_i != gold_sum);

    always_comb begin
        vec_next = vec_count_o;
        err_next = err_count_o;
        if (cmp_en && (vec_count_o != '1)) vec_next = vec_count_o + 1'b1;
        if (mismatch && (err_count_o != '1)) err_next = err_count_o + 1'b1;
    end

    // Control FSM; pass_o is taken from the next counter values so it is
    // already valid in the cycle done_o first rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            ops_valid   <= 1'b0;
            drain_cnt   <= '0;
            op_a_o      <= '0;
            op_b_o      <= '0;
            error_o     <= 1'b0;
            err_count_o <= '0;
            vec_count_o <= '0;
            fail_a_o    <= '0;
            fail_b_o    <= '0;
            fail_sum_o  <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
        end else begin
            err_count_o <= err_next;
            vec_count_o <= vec_next;
            if (mismatch && !error_o) begin
                error_o    <= 1'b1;
                fail_a_o   <= gold_a;
                fail_b_o   <= gold_b;
                fail_sum_o <= dut_sum_i;
            end

            case (state)
                IDLE: begin
                    op_a_o    <= '0;
                    op_b_o    <= '0;
                    ops_valid <= 1'b0;
                    acc       <= '0;
                    if (end_test_flag) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        pass_o <= (err_next == '0) && (vec_next != '0);
                    end else if (test_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (end_test_flag) begin
                        state     <= DRAIN;
                        ops_valid <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else if (!test_en) begin
                        state     <= IDLE;
                        op_a_o    <= '0;
                        op_b_o    <= '0;
                        ops_valid <= 1'b0;
                    end else begin
                        op_a_o    <= acc;
                        op_b_o    <= counter_ammount_i;
                        acc       <= acc + counter_ammount_i;
                        ops_valid <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        pass_o <= (err_next == '0) && (vec_next != '0);
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_k_sum_checker.sv
// Randomised bench for k_sum_checker: an emulated 1-cycle adder with optional
// faults feeds the design, and a transaction-level model predicts every output.
module tb_k_sum_checker;

    localparam int DW  = 6;
    localparam int LAT = 1;
    localparam int EW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          test_en = 1'b0;
    logic          end_test_flag = 1'b0;
    logic [DW-1:0] k = '0;
    logic [DW:0]   dut_sum = '0;
    logic [DW-1:0] op_a, op_b, fail_a, fail_b;
    logic [DW:0]   fail_sum;
    logic [EW-1:0] err_count, vec_count;
    logic          error, done, pass;

    always #5 clk = ~clk;

    k_sum_checker #(
        .DATA_WIDTH    (DW),
        .DUT_LATENCY   (LAT),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .test_en           (test_en),
        .counter_ammount_i (k),
        .end_test_flag     (end_test_flag),
        .op_a_o            (op_a),
        .op_b_o            (op_b),
        .dut_sum_i         (dut_sum),
        .error_o           (error),
        .err_count_o       (err_count),
        .vec_count_o       (vec_count),
        .fail_a_o          (fail_a),
        .fail_b_o          (fail_b),
        .fail_sum_o        (fail_sum),
        .done_o            (done),
        .pass_o            (pass)
    );

    int total = 0;
    int bad = 0;
    bit check_on = 1'b0;
    int fault_mode = 0;
    int fault_idx = 0;

    typedef struct {int a; int b; int s;} vec_t;
    vec_t pend[$];
    vec_t mv;
    int   m_mode, m_acc, m_a, m_b, m_idx, m_vec, m_err, m_fa, m_fb, m_fs;
    bit   m_valid, m_error, m_done, m_pass;

    function automatic int faulted(input int a, input int b, input int idx);
        int s;
        s = a + b;
        if (fault_mode == 1 && idx == fault_idx) s = (s + 1) % 128;
        if (fault_mode == 2) s = s % 64;
        return s;
    endfunction

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Adder emulation plus reference model; mode 0..3 = idle, run, drain, done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_sum <= '0;
            pend.delete();
            m_mode = 0; m_acc = 0; m_a = 0; m_b = 0; m_idx = 0;
            m_vec = 0; m_err = 0; m_fa = 0; m_fb = 0; m_fs = 0;
            m_valid = 0; m_error = 0; m_done = 0; m_pass = 0;
        end else begin
            dut_sum <= 7'(faulted(int'(op_a), int'(op_b), m_idx));
            while (pend.size() > 0) begin
                mv = pend.pop_front();
                m_vec++;
                if (mv.s != mv.a + mv.b) begin
                    m_err++;
                    if (!m_error) begin
                        m_error = 1; m_fa = mv.a; m_fb = mv.b; m_fs = mv.s;
                    end
                end
            end
            if (m_valid) pend.push_back('{m_a, m_b, faulted(m_a, m_b, m_idx)});
            case (m_mode)
                0: begin
                    m_acc = 0;
                    if (end_test_flag) begin
                        m_mode = 3; m_done = 1; m_pass = (m_err == 0) && (m_vec != 0);
                    end else if (test_en) m_mode = 1;
                end
                1: begin
                    if (end_test_flag) begin
                        m_mode = 2; m_valid = 0;
                    end else if (!test_en) begin
                        m_mode = 0; m_a = 0; m_b = 0; m_valid = 0; pend.delete();
                    end else begin
                        m_a = m_acc; m_b = int'(k); m_acc = (m_acc + int'(k)) % 64;
                        m_valid = 1; m_idx++;
                    end
                end
                2: begin
                    m_mode = 3; m_done = 1; m_pass = (m_err == 0) && (m_vec != 0);
                end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_on) begin
            check_output("op_a", int'(op_a), m_a);
            check_output("op_b", int'(op_b), m_b);
            check_output("err_count", int'(err_count), sat(m_err));
            check_output("vec_count", int'(vec_count), sat(m_vec));
            check_output("error", int'(error), int'(m_error));
            check_output("fail_a", int'(fail_a), m_fa);
            check_output("fail_b", int'(fail_b), m_fb);
            check_output("fail_sum", int'(fail_sum), m_fs);
            check_output("done", int'(done), int'(m_done));
            check_output("pass", int'(pass), int'(m_pass));
        end
    end

    task automatic apply_stimulus(input bit en, input int kv, input bit fin);
        test_en = en;
        k = DW'(kv);
        end_test_flag = fin;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        test_en = 0; end_test_flag = 0; k = '0; fault_mode = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic finish_run(input bit en);
        apply_stimulus(en, 0, 1);
        apply_stimulus(en, 0, 1);
    endtask

    int ks[8];
    int a5, n;

    initial begin
        do_reset();
        check_on = 1'b1;
        check_output("reset_done", int'(done), 0);
        check_output("reset_vec", int'(vec_count), 0);

        // Directed 1,2,3 sequence from acc=0.
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 1, 0);
        check_output("pair1_a", int'(op_a), 0); check_output("pair1_b", int'(op_b), 1);
        apply_stimulus(1, 2, 0);
        check_output("pair2_a", int'(op_a), 1); check_output("pair2_b", int'(op_b), 2);
        apply_stimulus(1, 3, 0);
        check_output("pair3_a", int'(op_a), 3); check_output("pair3_b", int'(op_b), 3);
        apply_stimulus(1, 0, 1);
        check_output("drain_not_done", int'(done), 0);
        apply_stimulus(1, 0, 1);
        check_output("dir_done", int'(done), 1);
        check_output("dir_pass", int'(pass), 1);
        check_output("dir_vec", int'(vec_count), 3);

        // Accumulator wrap with K=63.
        do_reset();
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 63, 0); check_output("wrap_a0", int'(op_a), 0);
        apply_stimulus(1, 63, 0); check_output("wrap_a1", int'(op_a), 63);
        apply_stimulus(1, 63, 0); check_output("wrap_a2", int'(op_a), 62);
        finish_run(1);
        check_output("wrap_pass", int'(pass), 1);
        check_output("wrap_err", int'(err_count), 0);

        // Single fault on the 5th vector.
        do_reset();
        fault_mode = 1; fault_idx = 5;
        apply_stimulus(1, 0, 0);
        a5 = 0;
        for (int i = 0; i < 8; i++) begin
            ks[i] = $urandom_range(0, 63);
            if (i < 4) a5 = (a5 + ks[i]) % 64;
            apply_stimulus(1, ks[i], 0);
        end
        finish_run(1);
        check_output("f5_err", int'(err_count), 1);
        check_output("f5_pass", int'(pass), 0);
        check_output("f5_fail_a", int'(fail_a), a5);
        check_output("f5_fail_b", int'(fail_b), ks[4]);
        check_output("f5_fail_sum", int'(fail_sum), (a5 + ks[4] + 1) % 128);

        // Stuck carry with K=32: every other vector fails, count saturates.
        do_reset();
        fault_mode = 2;
        apply_stimulus(1, 0, 0);
        repeat (40) apply_stimulus(1, 32, 0);
        check_output("carry_err_sat", int'(err_count), 15);
        check_output("carry_fail_a", int'(fail_a), 32);
        check_output("carry_fail_sum", int'(fail_sum), 0);
        finish_run(1);
        check_output("carry_pass", int'(pass), 0);

        // end_test_flag and test_en=0 together: drain then done.
        do_reset();
        apply_stimulus(1, 0, 0);
        repeat (4) apply_stimulus(1, $urandom_range(0, 63), 0);
        finish_run(0);
        check_output("both_done", int'(done), 1);
        check_output("both_vec", int'(vec_count), 4);

        // end_test_flag while idle.
        do_reset();
        apply_stimulus(1, 0, 1);
        check_output("idle_end_done", int'(done), 1);
        check_output("idle_end_pass", int'(pass), 0);

        // Asynchronous reset mid-run, then restart from acc=0.
        do_reset();
        fault_mode = 2;
        apply_stimulus(1, 0, 0);
        repeat (5) apply_stimulus(1, 32, 0);
        #2 rst_n = 1'b0;
        #1;
        check_output("arst_error", int'(error), 0);
        check_output("arst_op_b", int'(op_b), 0);
        check_output("arst_err", int'(err_count), 0);
        #1 rst_n = 1'b1;
        fault_mode = 0;
        @(negedge clk);
        apply_stimulus(1, 0, 0);
        apply_stimulus(1, 5, 0);
        check_output("restart_a", int'(op_a), 0);
        check_output("restart_b", int'(op_b), 5);

        // Randomised runs with enable drops, faults and DONE hold.
        for (int it = 0; it < 20; it++) begin
            do_reset();
            fault_mode = $urandom_range(0, 2);
            fault_idx = $urandom_range(1, 10);
            n = $urandom_range(3, 25);
            for (int j = 0; j < n; j++)
                apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 63), 0);
            finish_run($urandom_range(0, 1) != 0);
            apply_stimulus($urandom_range(0, 1) != 0, $urandom_range(0, 63), 0);
            check_output("rand_done", int'(done), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k_sum_checker.md
Name: k_sum_checker

Overview:
- Downstream consumer of the K-sequence counter in the FPGA adder tester.
- Each cycle it takes the current K value and forms an operand pair {A, K}; A is an internal accumulator stepped by K.
- It drives the pair to the adder under test (DUT) and computes the golden sum, delayed to match the DUT latency.
- It compares the DUT sum with the golden sum, counts mismatches and captures the first failing vector.
- When the counter raises end_test_flag, it drains the pipeline and reports pass/fail.

Parameters:
- DATA_WIDTH, 6: operand width; must match the K counter.
- DUT_LATENCY, 1: cycles from op_a_o/op_b_o change to the matching dut_sum_i; legal range 0..7.
- ERR_CNT_WIDTH, 16: width of the error and vector counters.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- test_en  in  1  level; 1 = run checking, 0 = hold in IDLE.
- counter_ammount_i  in  DATA_WIDTH  K value from the K counter.
- end_test_flag  in  1  sticky end-of-sequence flag from the K counter.
- op_a_o  out  DATA_WIDTH  DUT operand A (registered accumulator).
- op_b_o  out  DATA_WIDTH  DUT operand B (registered K).
- dut_sum_i  in  DATA_WIDTH+1  DUT result including carry-out.
- error_o  out  1  sticky; set on the first mismatch.
- err_count_o  out  ERR_CNT_WIDTH  mismatch count; saturates at all-ones.
- vec_count_o  out  ERR_CNT_WIDTH  number of compared vectors; saturates.
- fail_a_o, fail_b_o  out  DATA_WIDTH  operands of the first failing vector.
- fail_sum_o  out  DATA_WIDTH+1  DUT sum of the first failing vector.
- done_o  out  1  test finished; sticky until reset.
- pass_o  out  1  valid when done_o=1.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs are 0.
  - State = IDLE; accumulator = 0; delay-line valid bits = 0.
  - Reset asserted mid-run discards all state with no partial report.
- Clocking and arithmetic: single clock, all logic on the rising edge.
- IDLE:
  - op_a_o and op_b_o hold 0; no compares.
  - test_en=1 and end_test_flag=0 -> RUN on the next edge.
  - end_test_flag=1 -> DONE.
- RUN (each cycle):
  - op_b_o <= K.
  - op_a_o <= acc.
  - acc <= acc + K, mod 2^DATA_WIDTH (wrap, no saturation).
  - The golden sum {1'b0,op_a_o}+{1'b0,op_b_o} (DATA_WIDTH+1 bits) and a valid bit enter a delay line of DUT_LATENCY stages.
  - With DUT_LATENCY=0 the compare is combinational on the current outputs, registered into the counters.
- Compare:
  - When the delay-line output is valid, vec_count increments.
  - If dut_sum_i differs from the golden sum, err_count increments.
  - On the first mismatch only (error_o=0), fail_a/b/sum are captured and error_o is set.
  - Counters saturate; the capture registers never change after the first failure.
- RUN exits:
  - end_test_flag=1 (sampled) -> DRAIN. No new vectors enter; the delay line is injected with valid=0.
  - test_en=0 -> IDLE. Counters and error_o are kept; the delay line is flushed with no compares of in-flight vectors.
  - end_test_flag and test_en=0 in the same cycle -> end_test_flag wins (DRAIN).
- DRAIN:
  - Lasts exactly DUT_LATENCY cycles; in-flight vectors are still compared.
  - Then -> DONE. With DUT_LATENCY=0, DRAIN lasts 1 cycle.
- DONE:
  - done_o=1.
  - pass_o = (err_count==0) && (vec_count!=0).
  - Holds until reset; ignores test_en and K.
- The K value is sampled as-is; K=0 is a legal operand.

Decomposition:
- Shared package k_test_pkg:
  - DATA_WIDTH default.
  - Checker state encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - NUMBER_OF_COMBINATIONS, shared with the K counter.
- One sub-module: k_sum_delay_line, a parameterised shift register of {valid, golden sum}, depth DUT_LATENCY, with async active-low reset.
- FSM, accumulator, counters and capture logic stay in the top module.

Test Plan:
- Ideal DUT (dut_sum_i = op_a+op_b delayed 1 cycle), DATA_WIDTH=6:
  - K sequence 1,2,3 from acc=0 -> op pairs (0,1), (1,2), (3,3).
  - After end_test_flag and one DRAIN cycle: done_o=1, pass_o=1, err_count_o=0, vec_count_o = number of RUN cycles.
- Accumulator wrap: K=63 held for 3 cycles -> op_a_o goes 0, 63, 62; golden sums 63, 126, 125; with the ideal DUT, no errors.
- Fault injection: DUT output forced to a+b+1 on the 5th vector only -> error_o rises 1 cycle after that vector's result; err_count_o=1; fail_* equal the 5th pair and its bad sum; pass_o=0 at done.
- Persistent fault (stuck carry bit = 0) with K=32 repeatedly:
  - err_count_o counts every carry-out vector.
  - fail_* stay frozen at the first one.
  - With ERR_CNT_WIDTH=4, the count saturates at 15.
- Control boundaries:
  - end_test_flag and test_en=0 in the same cycle -> DRAIN, then DONE.
  - end_test_flag while in IDLE -> DONE with pass_o=0 (vec_count=0).
- Reset mid-RUN: rst_n pulsed low asynchronously between edges -> all outputs 0 immediately; after release with test_en=1, RUN restarts from acc=0.
